regfile_read_aligner: RTL and testbench
=======================================

# regfile_read_aligner

Read-side counterpart of the register-file write-address decode. Accepts a 5-bit operand address, issues the read to the 16×16 register file's synchronous read port, and aligns the returned data:
- Word registers pass through unchanged.
- Byte registers go to bits [7:0], zero- or sign-extended.

Write-port traffic in flight is merged per byte, so the result always reflects every write committed up to the cycle the result is registered.

## Interface
Parameters:
- registerAddressLength, 4, register-file address width (16 word registers)
- totalAddressLength, 5, operand address width
- dataLength, 16, register width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_req  input  1  read request, sampled every cycle; no backpressure
- rd_add  input  5  operand address: 0–15 word R0–R15, 16–23 low byte R0–R7, 24–31 high byte R0–R7
- rd_sext  input  1  sign-extend byte results (ignored for word reads); sampled with rd_req
- rf_rd_en  output  1  read enable to register file, = rd_req (combinational)
- rf_rd_add  output  4  register-file read address (combinational)
- rf_rd_data  input  16  register-file read data, valid the cycle after rf_rd_en
- w_en  input  1  register-file write strobe (same-cycle copy of the file's write controls)
- w_regfile_add  input  4  register-file write address
- w_lb  input  1  low byte written
- w_hb  input  1  high byte written
- w_data  input  16  write data, byte-lane aligned (high-byte writes on [15:8])
- rd_data  output  16  aligned result; reset 16'h0000; holds until next result
- rd_valid  output  1  one-cycle pulse when rd_data is new; reset 0

## Operation
Address decode (combinational, cycle T):
- rd_add < 16: rf_rd_add = rd_add[3:0]; lane = WORD.
- rd_add ≥ 16: rf_rd_add = {1'b0, rd_add[2:0]}; lane = LO if rd_add[3] = 0, else HI.

Stage 1, registered at end of T when rd_req = 1:
- Stores s1_valid, s1_add, lane, and rd_sext.
- Captures bypass bytes from a write at T to the same register (w_en & w_regfile_add == rf_rd_add): per-byte flags byp_lo / byp_hi plus their bytes from w_data.
- The register file does read-before-write at the same edge, so the returned data lacks this write.
- rd_req = 0: s1_valid ← 0; the other stage-1 fields are don't-care.

Stage 2, cycle T+1, when s1_valid:
- merged = rf_rd_data, with stage-1 bypass bytes substituted per lane.
- Then any write at T+1 to s1_add (w_en & w_regfile_add == s1_add) overrides per byte per w_lb / w_hb.
- Alignment:
  - WORD: merged.
  - LO: {ext, merged[7:0]}.
  - HI: {ext, merged[15:8]}.
  - ext = 8 copies of the selected byte's bit 7 if sext, else 8'h00.
- At end of T+1: rd_data ← aligned, rd_valid ← 1.
- When s1_valid = 0: rd_valid ← 0 and rd_data holds.

Writes with w_en = 0 never bypass, regardless of w_lb / w_hb. Back-to-back requests are fully pipelined: one result per cycle, in request order.

Reset (asynchronous, any time, including mid-pipeline):
- s1_valid, bypass flags, rd_valid ← 0; rd_data ← 0.
- In-flight requests are discarded; no result is ever produced for them.
- First request accepted at the first rising edge after rst deasserts.

## Timing
- Latency: request in cycle T → rd_valid high and rd_data valid throughout cycle T+2.
- rf_rd_en / rf_rd_add are combinational from rd_req / rd_add in T; no register on the issue path.
- Throughput: 1 request per cycle; there is no stall condition.
- Coherency point: rd_data includes all writes committed at edges ≤ end of T+1.
- rd_valid is high exactly one cycle per accepted request, and is never asserted from reset state without a request.

## Test plan
- R3 = 16'hA5C3, idle write port. Requests at consecutive cycles: rd_add = 3; rd_add = 19 with sext = 0; rd_add = 27 with sext = 1. Required: rd_valid for 3 consecutive cycles, with rd_data = A5C3, 00C3, FFA5.
- R5 = 16'h1234. In the request cycle for rd_add = 5, write R5 lo = 8'hEE (w_lb = 1, w_hb = 0). Required: rd_data = 12EE.
- R5 = 16'h1234. In the cycle after the request, write R5 hi = 8'h80 (w_data = 16'h80xx, w_hb = 1). Request rd_add = 29 with sext = 1. Required: rd_data = FF80.
- Both-cycle bypass on R2 = 0000: word write 16'hBEEF at T, then hi write 8'h11 at T+1. Request rd_add = 2. Required: rd_data = 11EF.
- Write to R6 while reading R7, and any write with w_en = 0. Required: no bypass; rf_rd_data is returned unchanged.
- Assert rst during T+1 of a pending request, then release. Required: rd_valid stays 0, rd_data = 0000, and the next request returns correct data 2 cycles later.

Source files
------------

// File: rtl/regfile_read_aligner.sv
// Read-side aligner for the 16x16 register file: decodes operand addresses, issues the
// synchronous read, merges in-flight write traffic per byte and aligns byte operands.
module regfile_read_aligner #(
    parameter int unsigned registerAddressLength = 4,
    parameter int unsigned totalAddressLength    = 5,
    parameter int unsigned dataLength            = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_req,
    input  logic [totalAddressLength-1:0]    rd_add,
    input  logic                             rd_sext,
    output logic                             rf_rd_en,
    output logic [registerAddressLength-1:0] rf_rd_add,
    input  logic [dataLength-1:0]            rf_rd_data,
    input  logic                             w_en,
    input  logic [registerAddressLength-1:0] w_regfile_add,
    input  logic                             w_lb,
    input  logic                             w_hb,
    input  logic [dataLength-1:0]            w_data,
    output logic [dataLength-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int unsigned ByteW = 8;
    localparam int unsigned ExtW  = dataLength - ByteW;

    typedef enum logic [1:0] {
        LaneWord,
        LaneLo,
        LaneHi
    } lane_e;

    lane_e                            lane_d, s1_lane_q, s1_lane_d;
    logic                             s1_valid_q, s1_valid_d;
    logic [registerAddressLength-1:0] s1_add_q, s1_add_d;
    logic                             s1_sext_q, s1_sext_d;
    logic                             byp_lo_q, byp_lo_d;
    logic                             byp_hi_q, byp_hi_d;
    logic [dataLength-1:0]            byp_data_q, byp_data_d;
    logic [dataLength-1:0]            rd_data_q, rd_data_d;
    logic                             rd_valid_q, rd_valid_d;

    logic                             wr_hit_s0;
    logic                             wr_hit_s1;
    logic [dataLength-1:0]            merged;
    logic [ByteW-1:0]                 sel_byte;
    logic [ExtW-1:0]                  ext;
    logic [dataLength-1:0]            aligned;

    // Issue path is purely combinational so the file sees the read in the request cycle.
    always_comb begin
        rf_rd_en = rd_req;
        if (rd_add[totalAddressLength-1]) begin
            rf_rd_add = {1'b0, rd_add[registerAddressLength-2:0]};
            lane_d    = rd_add[registerAddressLength-1] ? LaneHi : LaneLo;
        end else begin
            rf_rd_add = rd_add[registerAddressLength-1:0];
            lane_d    = LaneWord;
        end
    end

    // The file reads before it writes, so a same-edge write must be captured here.
    always_comb begin
        wr_hit_s0  = w_en && (w_regfile_add == rf_rd_add);
        s1_valid_d = rd_req;
        s1_add_d   = rf_rd_add;
        s1_lane_d  = lane_d;
        s1_sext_d  = rd_sext;
        byp_lo_d   = rd_req && wr_hit_s0 && w_lb;
        byp_hi_d   = rd_req && wr_hit_s0 && w_hb;
        byp_data_d = w_data;
    end

    always_comb begin
        wr_hit_s1 = w_en && (w_regfile_add == s1_add_q);
        merged    = rf_rd_data;
        if (byp_lo_q) begin
            merged[ByteW-1:0] = byp_data_q[ByteW-1:0];
        end
        if (byp_hi_q) begin
            merged[dataLength-1:ByteW] = byp_data_q[dataLength-1:ByteW];
        end
        // Writes landing on the result edge are newer than the stage-1 bypass.
        if (wr_hit_s1 && w_lb) begin
            merged[ByteW-1:0] = w_data[ByteW-1:0];
        end
        if (wr_hit_s1 && w_hb) begin
            merged[dataLength-1:ByteW] = w_data[dataLength-1:ByteW];
        end
    end

    always_comb begin
        sel_byte = (s1_lane_q == LaneHi) ? merged[dataLength-1:ByteW] : merged[ByteW-1:0];
        ext      = s1_sext_q ? {ExtW{sel_byte[ByteW-1]}} : '0;
        unique case (s1_lane_q)
            LaneLo, LaneHi: aligned = {ext, sel_byte};
            default:        aligned = merged;
        endcase
    end

    always_comb begin
        rd_valid_d = s1_valid_q;
        rd_data_d  = s1_valid_q ? aligned : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_add_q   <= '0;
            s1_lane_q  <= LaneWord;
            s1_sext_q  <= 1'b0;
            byp_lo_q   <= 1'b0;
            byp_hi_q   <= 1'b0;
            byp_data_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_add_q   <= s1_add_d;
            s1_lane_q  <= s1_lane_d;
            s1_sext_q  <= s1_sext_d;
            byp_lo_q   <= byp_lo_d;
            byp_hi_q   <= byp_hi_d;
            byp_data_q <= byp_data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_read_aligner.sv
// Bench for regfile_read_aligner: a 16x16 read-before-write register file plus a
// coherency-point reference model (result = register contents after edge T+1, aligned).
module tb_regfile_read_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [4:0]  rd_add = '0;
    logic        rd_sext = 1'b0;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_add;
    logic [15:0] rf_rd_data = '0;
    logic        w_en = 1'b0;
    logic [3:0]  w_regfile_add = '0;
    logic        w_lb = 1'b0;
    logic        w_hb = 1'b0;
    logic [15:0] w_data = '0;
    logic [15:0] rd_data;
    logic        rd_valid;

    logic [15:0] rf_mem [16];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [15:0] ref_mem [16];
    bit          pend_v    = 1'b0;
    int          pend_add  = 0;
    bit          pend_sext = 1'b0;
    bit          exp_valid = 1'b0;
    logic [15:0] exp_data  = '0;

    regfile_read_aligner dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req        (rd_req),
        .rd_add        (rd_add),
        .rd_sext       (rd_sext),
        .rf_rd_en      (rf_rd_en),
        .rf_rd_add     (rf_rd_add),
        .rf_rd_data    (rf_rd_data),
        .w_en          (w_en),
        .w_regfile_add (w_regfile_add),
        .w_lb          (w_lb),
        .w_hb          (w_hb),
        .w_data        (w_data),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    always #5 clk = ~clk;

    // Register file: synchronous read, reads old contents on a same-edge write.
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_add];
        if (w_en && w_lb) rf_mem[w_regfile_add][7:0] <= w_data[7:0];
        if (w_en && w_hb) rf_mem[w_regfile_add][15:8] <= w_data[15:8];
    end

    function automatic int reg_of(input int a);
        return (a < 16) ? a : (a % 8);
    endfunction

    function automatic logic [15:0] ref_align(input int a, input bit sext, input logic [15:0] w);
        logic [7:0] b;
        if (a < 16) return w;
        b = (a >= 24) ? w[15:8] : w[7:0];
        return (sext && b[7]) ? {8'hFF, b} : {8'h00, b};
    endfunction

    task automatic set_in(input logic req, input logic [4:0] add, input logic sext,
                          input logic wen, input logic [3:0] wadd, input logic lb,
                          input logic hb, input logic [15:0] wd);
        rd_req = req; rd_add = add; rd_sext = sext;
        w_en = wen; w_regfile_add = wadd; w_lb = lb; w_hb = hb; w_data = wd;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Advance the model across the coming edge, then let the edge happen.
    task automatic tick();
        if (w_en && w_lb) ref_mem[w_regfile_add][7:0] = w_data[7:0];
        if (w_en && w_hb) ref_mem[w_regfile_add][15:8] = w_data[15:8];
        if (rst) begin
            pend_v = 1'b0; exp_valid = 1'b0; exp_data = '0;
        end else begin
            exp_valid = pend_v;
            if (pend_v) exp_data = ref_align(pend_add, pend_sext, ref_mem[reg_of(pend_add)]);
            pend_v = rd_req; pend_add = int'(rd_add); pend_sext = rd_sext;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [15:0] v);
        set_in(1'b0, 5'd0, 1'b0, 1'b1, idx, 1'b1, 1'b1, v);
        tick();
        idle();
    endtask

    task automatic test_reset();
        set_in(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b0 || rd_data !== 16'h0000)
                $display("FAIL reset_state: got valid=%b data=%h, want valid=0 data=0000",
                         rd_valid, rd_data);
            else n_pass++;
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b0 || rd_data !== 16'h0000)
                $display("FAIL reset_no_spurious: got valid=%b data=%h, want 0/0000",
                         rd_valid, rd_data);
            else n_pass++;
        end
    endtask

    task automatic test_align();
        logic [4:0]  adds [3];
        logic        sx   [3];
        logic [15:0] want [3];
        adds = '{5'd3, 5'd19, 5'd27};
        sx   = '{1'b0, 1'b0, 1'b1};
        want = '{16'hA5C3, 16'h00C3, 16'hFFA5};
        preload(4'd3, 16'hA5C3);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_in(1'b1, adds[i], sx[i], 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
            else idle();
            tick();
            n_checks++;
            if (rd_valid !== exp_valid || rd_data !== exp_data)
                $display("FAIL align_model[%0d]: got %b/%h, want %b/%h",
                         i, rd_valid, rd_data, exp_valid, exp_data);
            else n_pass++;
            if (i >= 1 && i <= 3) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== want[i-1])
                    $display("FAIL align_vec[%0d]: got %b/%h, want 1/%h",
                             i - 1, rd_valid, rd_data, want[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bypass_same_cycle();
        preload(4'd5, 16'h1234);
        set_in(1'b1, 5'd5, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 16'h77EE);
        tick();
        idle();
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h12EE)
            $display("FAIL bypass_t: got %b/%h, want 1/12EE", rd_valid, rd_data);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h12EE)
            $display("FAIL bypass_t_hold: got %b/%h, want 0/12EE", rd_valid, rd_data);
        else n_pass++;
    endtask

    task automatic test_bypass_next_cycle();
        preload(4'd5, 16'h1234);
        set_in(1'b1, 5'd29, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        tick();
        set_in(1'b0, 5'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 16'h8033);
        tick();
        idle();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hFF80)
            $display("FAIL bypass_t1: got %b/%h, want 1/FF80", rd_valid, rd_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_bypass_both();
        preload(4'd2, 16'h0000);
        set_in(1'b1, 5'd2, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 16'hBEEF);
        tick();
        set_in(1'b0, 5'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 16'h1100);
        tick();
        idle();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h11EF)
            $display("FAIL bypass_both: got %b/%h, want 1/11EF", rd_valid, rd_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_no_bypass();
        preload(4'd7, 16'h5A3C);
        preload(4'd6, 16'h0000);
        set_in(1'b1, 5'd7, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 16'hFFFF);
        tick();
        set_in(1'b1, 5'd23, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 16'h0000);
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h5A3C)
            $display("FAIL no_bypass_other_reg: got %b/%h, want 1/5A3C", rd_valid, rd_data);
        else n_pass++;
        set_in(1'b0, 5'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 16'h1111);
        tick();
        idle();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h003C)
            $display("FAIL no_bypass_wen0: got %b/%h, want 1/003C", rd_valid, rd_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        preload(4'd4, 16'hC0DE);
        set_in(1'b1, 5'd4, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        tick();
        idle();
        rst = 1'b1;
        pend_v = 1'b0; exp_valid = 1'b0; exp_data = '0;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000)
            $display("FAIL reset_async: got %b/%h, want 0/0000", rd_valid, rd_data);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000)
            $display("FAIL reset_discard: got %b/%h, want 0/0000", rd_valid, rd_data);
        else n_pass++;
        rst = 1'b0;
        set_in(1'b1, 5'd28, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        tick();
        idle();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000)
            $display("FAIL reset_no_stale: got %b/%h, want 0/0000", rd_valid, rd_data);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hFFC0)
            $display("FAIL reset_recover: got %b/%h, want 1/FFC0", rd_valid, rd_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] want_add;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) != 0, 5'($urandom_range(0, 31)), 1'($urandom),
                   1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                   16'($urandom));
            #1;
            want_add = 4'(reg_of(int'(rd_add)));
            n_checks++;
            if (rf_rd_en !== rd_req || rf_rd_add !== want_add)
                $display("FAIL issue[%0d]: got en=%b add=%h, want en=%b add=%h",
                         i, rf_rd_en, rf_rd_add, rd_req, want_add);
            else n_pass++;
            tick();
            n_checks++;
            if (rd_valid !== exp_valid || rd_data !== exp_data)
                $display("FAIL random[%0d]: got %b/%h, want %b/%h",
                         i, rd_valid, rd_data, exp_valid, exp_data);
            else n_pass++;
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== exp_valid || rd_data !== exp_data)
                $display("FAIL random_drain[%0d]: got %b/%h, want %b/%h",
                         i, rd_valid, rd_data, exp_valid, exp_data);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        #1;
        test_reset();
        test_align();
        test_bypass_same_cycle();
        test_bypass_next_cycle();
        test_bypass_both();
        test_no_bypass();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
